// File: rtl/dmem_access_pkg.sv
// Shared types for the memory-stage data-bus master: operation codes, FSM state
// encodings, the registered memory-to-writeback record and operation helpers.
package dmem_access_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_SB,
        OP_SH,
        OP_SW
    } mem_op_t;

    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t S_IDLE  = 2'd0;
    localparam dmem_state_t S_ADDR  = 2'd1;
    localparam dmem_state_t S_DATA  = 2'd2;
    localparam dmem_state_t S_DRAIN = 2'd3;

    typedef struct packed {
        logic        valid;
        logic        memread;
        logic [31:0] rd;
        logic [31:0] aluout;
        logic [4:0]  writereg;
        logic        adel;
        logic        ades;
        logic [31:0] badvaddr;
    } mem_wb_t;

    function automatic logic op_is_load(input mem_op_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] offset);
        case (op)
            OP_LH, OP_LHU, OP_SH: return offset[0];
            OP_LW, OP_SW:         return offset != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_if.sv
// SRAM-like data bus: the request phase ends on d_addr_ok, the data phase on d_data_ok.
interface dmem_access_if;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    modport master (
        output d_req, d_wr, d_size, d_addr, d_wdata, d_wstrb,
        input  d_addr_ok, d_data_ok, d_rdata
    );

    modport slave (
        input  d_req, d_wr, d_size, d_addr, d_wdata, d_wstrb,
        output d_addr_ok, d_data_ok, d_rdata
    );
endinterface

// File: rtl/dmem_access_mem_align.sv
// Combinational lane logic: store replication/strobes and load extraction with
// sign or zero extension, all keyed off the operation and the low address bits.
module dmem_access_mem_align
    import dmem_access_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [1:0]  size,
    output logic        wr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_fmt,
    output logic [31:0] rdata_ext
);
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        size      = 2'd0;
        wr        = 1'b0;
        wstrb     = 4'b0000;
        wdata_fmt = 32'h0;
        rdata_ext = 32'h0;
        byte_sel  = lane[offset];
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: rdata_ext = {24'h0, byte_sel};
            OP_LH: begin
                size      = 2'd1;
                rdata_ext = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                size      = 2'd1;
                rdata_ext = {16'h0, half_sel};
            end
            OP_LW: begin
                size      = 2'd2;
                rdata_ext = rdata;
            end
            OP_SB: begin
                wr        = 1'b1;
                wstrb     = 4'b0001 << offset;
                wdata_fmt = {4{wdata[7:0]}};
            end
            OP_SH: begin
                size      = 2'd1;
                wr        = 1'b1;
                wstrb     = offset[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{wdata[15:0]}};
            end
            OP_SW: begin
                size      = 2'd2;
                wr        = 1'b1;
                wstrb     = 4'b1111;
                wdata_fmt = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// Memory-stage data-bus master: request/data-phase FSM, flush and drain handling,
// address-error detection and the registered memory-to-writeback record.
module dmem_access
    import dmem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  mem_op_t     ex_memop,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_aluout,
    input  logic [4:0]  ex_writereg,
    input  logic        flush,
    output logic        stall,
    dmem_access_if.master bus,
    output logic        wb_valid,
    output logic        wb_memread,
    output logic [31:0] wb_rd,
    output logic [31:0] wb_aluout,
    output logic [4:0]  wb_writereg,
    output logic        wb_adel,
    output logic        wb_ades,
    output logic [31:0] wb_badvaddr
);
    dmem_state_t state_reg, state_next;
    mem_op_t     op_reg;
    logic [31:0] addr_reg, wdata_reg, aluout_reg;
    logic [4:0]  writereg_reg;
    mem_wb_t     wb_reg, wb_next, pend_reg, pend_next;
    mem_wb_t     done_rec, pass_rec;
    logic        bus_done, accept, load_ex, ex_misaligned;
    logic [1:0]  fmt_size;
    logic        fmt_wr;
    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_wdata, rdata_ext;

    dmem_access_mem_align u_align (
        .op        (op_reg),
        .offset    (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .rdata     (bus.d_rdata),
        .size      (fmt_size),
        .wr        (fmt_wr),
        .wstrb     (fmt_wstrb),
        .wdata_fmt (fmt_wdata),
        .rdata_ext (rdata_ext)
    );

    // Bus fields come straight from the latched request, so they stay stable until d_addr_ok.
    assign bus.d_req   = (state_reg == S_ADDR);
    assign bus.d_wr    = fmt_wr;
    assign bus.d_size  = fmt_size;
    assign bus.d_addr  = addr_reg;
    assign bus.d_wdata = fmt_wdata;
    assign bus.d_wstrb = fmt_wstrb;

    assign bus_done = ((state_reg == S_ADDR) && bus.d_addr_ok && bus.d_data_ok) ||
                      ((state_reg == S_DATA) && bus.d_data_ok);
    // A parked pass-through record occupies the writeback slot for one cycle.
    assign stall         = ((state_reg != S_IDLE) && !bus_done) || pend_reg.valid;
    assign accept        = ex_valid && !stall && !flush;
    assign ex_misaligned = op_misaligned(ex_memop, ex_addr[1:0]);

    always_comb begin
        done_rec          = '0;
        done_rec.valid    = 1'b1;
        done_rec.memread  = op_is_load(op_reg);
        done_rec.rd       = op_is_load(op_reg) ? rdata_ext : 32'h0;
        done_rec.aluout   = aluout_reg;
        done_rec.writereg = writereg_reg;

        pass_rec          = '0;
        pass_rec.valid    = 1'b1;
        pass_rec.aluout   = ex_aluout;
        pass_rec.writereg = ex_writereg;
        pass_rec.adel     = ex_misaligned && op_is_load(ex_memop);
        pass_rec.ades     = ex_misaligned && op_is_store(ex_memop);
        pass_rec.badvaddr = ex_misaligned ? ex_addr : 32'h0;

        state_next    = state_reg;
        wb_next       = wb_reg;
        wb_next.valid = 1'b0;
        pend_next     = '0;
        load_ex       = 1'b0;

        if (pend_reg.valid) begin
            wb_next = pend_reg;
        end

        case (state_reg)
            S_ADDR: begin
                if (bus.d_addr_ok) begin
                    if (bus.d_data_ok) begin
                        state_next = S_IDLE;
                        if (!flush) wb_next = done_rec;
                    end else begin
                        state_next = flush ? S_DRAIN : S_DATA;
                    end
                end else if (flush) begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (bus.d_data_ok) begin
                    state_next = S_IDLE;
                    if (!flush) wb_next = done_rec;
                end else if (flush) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.d_data_ok) state_next = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            if ((ex_memop == OP_NONE) || ex_misaligned) begin
                // Collides with a bus completion only when accepted in the completion cycle.
                if (wb_next.valid) pend_next = pass_rec;
                else               wb_next   = pass_rec;
            end else begin
                state_next = S_ADDR;
                load_ex    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            op_reg       <= OP_NONE;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            aluout_reg   <= 32'h0;
            writereg_reg <= 5'h0;
            wb_reg       <= '0;
            pend_reg     <= '0;
        end else begin
            state_reg <= state_next;
            wb_reg    <= wb_next;
            pend_reg  <= pend_next;
            if (load_ex) begin
                op_reg       <= ex_memop;
                addr_reg     <= ex_addr;
                wdata_reg    <= ex_wdata;
                aluout_reg   <= ex_aluout;
                writereg_reg <= ex_writereg;
            end
        end
    end

    assign wb_valid    = wb_reg.valid;
    assign wb_memread  = wb_reg.memread;
    assign wb_rd       = wb_reg.rd;
    assign wb_aluout   = wb_reg.aluout;
    assign wb_writereg = wb_reg.writereg;
    assign wb_adel     = wb_reg.adel;
    assign wb_ades     = wb_reg.ades;
    assign wb_badvaddr = wb_reg.badvaddr;

endmodule

// File: tb/tb_dmem_access.sv
// Bench for dmem_access: vector table applied through a scripted bus slave, with a
// writeback scoreboard, plus hand sequences for back-to-back, flush and reset cases.
module tb_dmem_access;
    import dmem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    mem_op_t     ex_memop = OP_NONE;
    logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0, ex_aluout = 32'h0;
    logic [4:0]  ex_writereg = 5'h0;
    logic        flush = 1'b0;
    logic        stall;
    logic        wb_valid, wb_memread, wb_adel, wb_ades;
    logic [31:0] wb_rd, wb_aluout, wb_badvaddr;
    logic [4:0]  wb_writereg;

    int total = 0;
    int bad   = 0;

    dmem_access_if bus ();

    dmem_access dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_memop    (ex_memop),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .ex_aluout   (ex_aluout),
        .ex_writereg (ex_writereg),
        .flush       (flush),
        .stall       (stall),
        .bus         (bus),
        .wb_valid    (wb_valid),
        .wb_memread  (wb_memread),
        .wb_rd       (wb_rd),
        .wb_aluout   (wb_aluout),
        .wb_writereg (wb_writereg),
        .wb_adel     (wb_adel),
        .wb_ades     (wb_ades),
        .wb_badvaddr (wb_badvaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        memread;
        logic        chk_rd;
        logic [31:0] rd;
        logic [31:0] aluout;
        logic [4:0]  writereg;
        logic        adel;
        logic        ades;
        logic [31:0] badvaddr;
    } exp_t;

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        logic [31:0] exp_rd;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [1:0]  exp_size;
        logic        exp_memread;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] alu, input logic [4:0] wreg);
        ex_valid    = 1'b1;
        ex_memop    = op;
        ex_addr     = addr;
        ex_wdata    = wdata;
        ex_aluout   = alu;
        ex_writereg = wreg;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0;
        ex_memop = OP_NONE;
    endtask

    function automatic exp_t load_exp(input logic [31:0] rd, input logic [31:0] alu,
                                      input logic [4:0] wreg);
        exp_t e;
        e = '{memread: 1'b1, chk_rd: 1'b1, rd: rd, aluout: alu, writereg: wreg,
              adel: 1'b0, ades: 1'b0, badvaddr: 32'h0};
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_stall"},   32'(stall), 32'h0);
        check({tag, "_d_req"},   32'(bus.d_req), 32'h0);
        check({tag, "_d_addr"},  bus.d_addr, 32'h0);
        check({tag, "_d_wdata"}, bus.d_wdata, 32'h0);
        check({tag, "_d_ctl"},   32'({bus.d_wr, bus.d_size, bus.d_wstrb}), 32'h0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'h0);
        check({tag, "_wb_rd"},   wb_rd, 32'h0);
        check({tag, "_wb_alu"},  wb_aluout, 32'h0);
        check({tag, "_wb_bad"},  wb_badvaddr, 32'h0);
        check({tag, "_wb_flags"}, 32'({wb_memread, wb_adel, wb_ades, wb_writereg}), 32'h0);
    endtask

    task automatic check_bus(input vec_t v);
        check("d_req",   32'(bus.d_req), 32'h1);
        check("d_addr",  bus.d_addr, v.addr);
        check("d_wr",    32'(bus.d_wr), 32'(v.exp_wstrb != 4'b0000));
        check("d_size",  32'(bus.d_size), 32'(v.exp_size));
        check("d_wstrb", 32'(bus.d_wstrb), 32'(v.exp_wstrb));
        if (v.exp_wstrb != 4'b0000) check("d_wdata", bus.d_wdata, v.exp_wdata);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        logic [31:0] alu;
        logic [4:0]  wreg;
        bit          mem;
        alu  = 32'h1000_0000 + 32'(idx);
        wreg = 5'(idx + 1);
        mem  = (v.op != OP_NONE) && !v.exp_adel && !v.exp_ades;
        e = '{memread: v.exp_memread, chk_rd: v.exp_memread, rd: v.exp_rd, aluout: alu,
              writereg: wreg, adel: v.exp_adel, ades: v.exp_ades, badvaddr: v.addr};
        drive_ex(v.op, v.addr, v.wdata, alu, wreg);
        sb.push_back(e);
        @(negedge clk);
        check("accept_stall", 32'(stall), 32'h0);
        tick();
        clear_ex();
        if (!mem) begin
            @(negedge clk);
            check("no_req", 32'(bus.d_req), 32'h0);
        end else begin
            for (int c = 0; c < v.aw; c++) begin
                @(negedge clk);
                check_bus(v);
                check("addr_wait_stall", 32'(stall), 32'h1);
                tick();
            end
            bus.d_addr_ok = 1'b1;
            if (v.dw == 0) begin
                bus.d_data_ok = 1'b1;
                bus.d_rdata   = v.rdata;
            end
            @(negedge clk);
            check_bus(v);
            check("addr_ok_stall", 32'(stall), 32'(v.dw != 0));
            tick();
            bus.d_addr_ok = 1'b0;
            bus.d_data_ok = 1'b0;
            if (v.dw > 0) begin
                for (int c = 1; c < v.dw; c++) begin
                    @(negedge clk);
                    check("data_wait_req", 32'(bus.d_req), 32'h0);
                    check("data_wait_stall", 32'(stall), 32'h1);
                    tick();
                end
                bus.d_data_ok = 1'b1;
                bus.d_rdata   = v.rdata;
                @(negedge clk);
                check("data_ok_stall", 32'(stall), 32'h0);
                tick();
                bus.d_data_ok = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        check("wb_timing", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;
        $display("vec %0d op=%s addr=%h wb_rd=%h", idx, v.op.name(), v.addr, wb_rd);
    endtask

    // Scoreboard: every wb_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got wb_valid=1 aluout=%h required no record", wb_aluout);
            end else begin
                mon_e = sb.pop_front();
                check("wb_memread", 32'(wb_memread), 32'(mon_e.memread));
                if (mon_e.chk_rd) check("wb_rd", wb_rd, mon_e.rd);
                check("wb_aluout", wb_aluout, mon_e.aluout);
                check("wb_writereg", 32'(wb_writereg), 32'(mon_e.writereg));
                check("wb_adel", 32'(wb_adel), 32'(mon_e.adel));
                check("wb_ades", 32'(wb_ades), 32'(mon_e.ades));
                if (mon_e.adel || mon_e.ades) check("wb_badvaddr", wb_badvaddr, mon_e.badvaddr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish before 100000ns");
        $fatal(1, "timeout");
    end

    initial begin
        bus.d_addr_ok = 1'b0;
        bus.d_data_ok = 1'b0;
        bus.d_rdata   = 32'h0;

        //          op       addr          wdata         rdata         aw dw  rd            wdata         strb     sz    mr    adel  ades
        vecs[0]  = '{OP_LW,  32'h80000010, 32'h00000000, 32'hDEADBEEF, 2, 3, 32'hDEADBEEF, 32'h00000000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{OP_LB,  32'h80000013, 32'h00000000, 32'h80112233, 0, 0, 32'hFFFFFF80, 32'h00000000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{OP_LBU, 32'h80000013, 32'h00000000, 32'h80112233, 1, 1, 32'h00000080, 32'h00000000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{OP_SH,  32'h80000012, 32'h0000ABCD, 32'h00000000, 0, 1, 32'h00000000, 32'hABCDABCD, 4'b1100, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_LH,  32'h80000011, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 32'h00000000, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{OP_NONE, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 32'h00000000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_SB,  32'h80000021, 32'h000000A5, 32'h00000000, 1, 0, 32'h00000000, 32'hA5A5A5A5, 4'b0010, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_SW,  32'h80000024, 32'hCAFEF00D, 32'h00000000, 0, 2, 32'h00000000, 32'hCAFEF00D, 4'b1111, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_SW,  32'h80000026, 32'h12345678, 32'h00000000, 0, 0, 32'h00000000, 32'h00000000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{OP_LH,  32'h80000022, 32'h00000000, 32'h80017FFF, 0, 2, 32'hFFFF8001, 32'h00000000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_LHU, 32'h80000020, 32'h00000000, 32'h1234F00D, 3, 0, 32'h0000F00D, 32'h00000000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{OP_LB,  32'h80000020, 32'h00000000, 32'h1234567F, 0, 0, 32'h0000007F, 32'h00000000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{OP_LHU, 32'h80000023, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 32'h00000000, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{OP_LBU, 32'h80000021, 32'h00000000, 32'h0000AB00, 1, 0, 32'h000000AB, 32'h00000000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{OP_LH,  32'h80000020, 32'h00000000, 32'h0000FFFE, 0, 1, 32'hFFFFFFFE, 32'h00000000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{OP_SB,  32'h80000023, 32'hFFFFFF3C, 32'h00000000, 0, 0, 32'h00000000, 32'h3C3C3C3C, 4'b1000, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{OP_SH,  32'h80000020, 32'h12345678, 32'h00000000, 2, 1, 32'h00000000, 32'h56785678, 4'b0011, 2'd1, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Back-to-back loads, each completing with addr_ok and data_ok together.
        drive_ex(OP_LW, 32'h80000030, 32'h0, 32'h20000001, 5'd9);
        sb.push_back(load_exp(32'h11111111, 32'h20000001, 5'd9));
        @(negedge clk);
        check("b2b_accept_stall", 32'(stall), 32'h0);
        tick();
        clear_ex();
        bus.d_addr_ok = 1'b1;
        bus.d_data_ok = 1'b1;
        bus.d_rdata   = 32'h11111111;
        drive_ex(OP_LW, 32'h80000034, 32'h0, 32'h20000002, 5'd10);
        sb.push_back(load_exp(32'h22222222, 32'h20000002, 5'd10));
        @(negedge clk);
        check("b2b_done_stall", 32'(stall), 32'h0);
        check("b2b_addr1", bus.d_addr, 32'h80000030);
        tick();
        bus.d_addr_ok = 1'b0;
        bus.d_data_ok = 1'b0;
        clear_ex();
        @(negedge clk);
        check("b2b_req2", 32'(bus.d_req), 32'h1);
        check("b2b_addr2", bus.d_addr, 32'h80000034);
        #1;
        check("b2b_wb1_timing", 32'(sb.size()), 32'h1);
        bus.d_addr_ok = 1'b1;
        bus.d_data_ok = 1'b1;
        bus.d_rdata   = 32'h22222222;
        tick();
        bus.d_addr_ok = 1'b0;
        bus.d_data_ok = 1'b0;
        @(negedge clk);
        #1;
        check("b2b_wb2_timing", 32'(sb.size()), 32'h0);
        tick();
        $display("seq back_to_back wb_rd=%h", wb_rd);

        // Flush during the request phase drops the request without a record.
        drive_ex(OP_LW, 32'h80000040, 32'h0, 32'h30000000, 5'd3);
        tick();
        clear_ex();
        flush = 1'b1;
        @(negedge clk);
        check("flush_addr_req", 32'(bus.d_req), 32'h1);
        check("flush_addr_stall", 32'(stall), 32'h1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_addr_req_drop", 32'(bus.d_req), 32'h0);
        check("flush_addr_stall_rel", 32'(stall), 32'h0);
        check("flush_addr_no_wb", 32'(wb_valid), 32'h0);
        tick();
        // Flush wins over acceptance in the same cycle.
        drive_ex(OP_NONE, 32'h0, 32'h0, 32'h30000001, 5'd4);
        flush = 1'b1;
        tick();
        clear_ex();
        flush = 1'b0;
        @(negedge clk);
        check("flush_prio_no_wb", 32'(wb_valid), 32'h0);
        tick();
        $display("seq flush_addr done");

        // Flush during the data phase drains the outstanding response.
        drive_ex(OP_LW, 32'h80000044, 32'h0, 32'h30000002, 5'd5);
        tick();
        clear_ex();
        bus.d_addr_ok = 1'b1;
        tick();
        bus.d_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_data_req", 32'(bus.d_req), 32'h0);
        check("flush_data_stall", 32'(stall), 32'h1);
        tick();
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("drain_stall", 32'(stall), 32'h1);
            tick();
        end
        bus.d_data_ok = 1'b1;
        bus.d_rdata   = 32'h55555555;
        @(negedge clk);
        check("drain_last_stall", 32'(stall), 32'h1);
        tick();
        bus.d_data_ok = 1'b0;
        @(negedge clk);
        check("drain_release", 32'(stall), 32'h0);
        check("drain_no_wb", 32'(wb_valid), 32'h0);
        tick();
        $display("seq flush_data done");

        // Asynchronous reset while waiting for data; the late data_ok must be ignored.
        drive_ex(OP_LW, 32'h80000048, 32'h0, 32'h30000003, 5'd6);
        tick();
        clear_ex();
        bus.d_addr_ok = 1'b1;
        tick();
        bus.d_addr_ok = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.d_data_ok = 1'b1;
        bus.d_rdata   = 32'h66666666;
        @(negedge clk);
        check("late_data_no_wb", 32'(wb_valid), 32'h0);
        check("late_data_stall", 32'(stall), 32'h0);
        tick();
        bus.d_data_ok = 1'b0;
        @(negedge clk);
        check("late_data_no_wb2", 32'(wb_valid), 32'h0);
        check("late_data_sb", 32'(sb.size()), 32'h0);
        tick();
        $display("seq reset_in_data done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
